// File: rtl/coherence_bus_ctrl.sv
// Two-core MSI coherence bus controller: round-robin arbitration, one-cycle snoop,
// word-beat block loads, evictions, and cache-to-cache transfer with RAM writeback.
module coherence_bus_ctrl #(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  input  logic [CPUS-1:0]       cctrans,
  input  logic [CPUS-1:0]       ccwrite,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output logic [CPUS-1:0][31:0] ccsnoopaddr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate
);

  localparam int BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, SNOOP, LOAD, C2C, WB} state_e;

  state_e            state, state_next;
  logic              req, req_next;
  logic              prio, prio_next;
  logic [BEAT_W-1:0] beat, beat_next;

  logic [CPUS-1:0] want;
  logic            grant;
  logic            oth;
  logic            access;
  logic            last;

  // A read miss always arrives with cctrans, so dREN carries no extra information here.
  logic unused_dren;
  assign unused_dren = ^dREN;

  assign want   = dWEN | cctrans;
  assign oth    = ~req;
  assign access = (ramstate == RAM_ACCESS);
  assign last   = (beat == BEAT_W'(BLOCK_WORDS - 1));

  // Both requesting: favoured core wins; otherwise the lone requester.
  assign grant = want[1] & (~want[0] | prio);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      req   <= 1'b0;
      prio  <= 1'b0;
      beat  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state <= state_next;
      req   <= req_next;
      prio  <= prio_next;
      beat  <= beat_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_next = state;
    req_next   = req;
    prio_next  = prio;
    beat_next  = beat;
    unique case (state)
      IDLE: begin
        if (|want) begin
          req_next   = grant;
          state_next = cctrans[grant] ? SNOOP : WB;
        end
      end
      SNOOP: state_next = ccwrite[oth] ? C2C : LOAD;
      LOAD, C2C, WB: begin
        if (access) begin
          if (last) begin
            state_next = IDLE;
            beat_next  = '0;
            prio_next  = ~req;
          end else begin
            beat_next = beat + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    // The snoop stays visible to the other cache for the whole bus transaction.
    if (state == SNOOP || state == LOAD || state == C2C) begin
      ccwait[oth]      = 1'b1;
      ccinv[oth]       = ccwrite[req];
      ccsnoopaddr[oth] = daddr[req];
    end

    unique case (state)
      LOAD: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[req];
        dload[req] = ramload;
        if (access) dwait[req] = 1'b0;
      end
      C2C: begin
        // Snooper's dirty word goes to RAM and to the requester in the same beat.
        ramWEN     = 1'b1;
        ramaddr    = daddr[oth];
        ramstore   = dstore[oth];
        dload[req] = dstore[oth];
        if (access) dwait = '0;
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req];
        ramstore = dstore[req];
        if (access) dwait[req] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: bench plays both caches and the RAM and
// predicts every bus beat from a word-level memory model and the round-robin rule.
module tb_coherence_bus_ctrl;

  localparam int BW = 2;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] daddr, dstore, dload, ccsnoopaddr;
  logic [1:0]       dwait, ccwait, ccinv;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram    [logic [31:0]];
  logic [31:0] golden [logic [31:0]];
  bit          m_prio;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.CPUS(2), .BLOCK_WORDS(BW)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : init_word(a);
  endfunction

  function automatic logic [1:0] stall_state();
    case ($urandom_range(0, 2))
      0:       return R_FREE;
      1:       return R_BUSY;
      default: return R_ERROR;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = R_FREE;
  endtask

  // One whole transaction for core r, starting in the IDLE cycle in which it requests.
  // stall < 0 picks a random number of non-ACCESS cycles per beat; abort_beat >= 0
  // pulls reset at the start of that beat.
  task automatic serve(input int r, input bit wb, input bit rdx, input bit supply,
                       input logic [31:0] base, input int stall, input int abort_beat,
                       input logic [31:0] d [BW]);
    int          o;
    int          waits;
    bit          acc;
    logic [31:0] a;
    logic [1:0]  exp_dw;
    o = 1 - r;
    daddr[r] = base;
    if (wb) begin
      dWEN[r] = 1'b1;
    end else begin
      cctrans[r] = 1'b1;
      dREN[r]    = 1'b1;
      ccwrite[r] = rdx;
    end

    @(negedge CLK);
    check("arb_dwait", dwait, 2'b11);
    check("arb_ram", {ramREN, ramWEN}, 2'b00);
    tick();

    if (!wb) begin
      if (supply) begin
        ccwrite[o] = 1'b1; dWEN[o] = 1'b1; daddr[o] = base; dstore[o] = d[0];
      end
      @(negedge CLK);
      check("snp_ccwait", ccwait, (o == 1) ? 2'b10 : 2'b01);
      check("snp_ccinv", ccinv[o], rdx);
      check("snp_addr", ccsnoopaddr[o], base);
      check("snp_dwait", dwait, 2'b11);
      check("snp_ram", {ramREN, ramWEN}, 2'b00);
      tick();
    end

    for (int k = 0; k < BW; k++) begin
      a = base + 32'(4 * k);
      daddr[r] = a;
      if (wb) dstore[r] = d[k];
      if (supply) begin daddr[o] = a; dstore[o] = d[k]; end
      waits = (stall < 0) ? $urandom_range(0, 3) : stall;
      for (int c = 0; c <= waits; c++) begin
        acc      = (c == waits);
        ramstate = acc ? R_ACCESS : stall_state();
        ramload  = ram_rd(a);
        if (k == abort_beat) begin
          #2 nRST = 1'b0;
          #1;
          check("rst_ramwen", ramWEN, 1'b0);
          check("rst_ccwait", ccwait, 2'b00);
          check("rst_dwait", dwait, 2'b11);
          check("rst_dload", dload[r], 32'h0);
          check("rst_ramaddr", ramaddr, 32'h0);
          clear_inputs();
          tick();
          nRST   = 1'b1;
          m_prio = 1'b0;
          return;
        end
        @(negedge CLK);
        exp_dw = 2'b11;
        if (acc) exp_dw[r] = 1'b0;
        if (acc && supply) exp_dw[o] = 1'b0;
        check("beat_dwait", dwait, exp_dw);
        check("beat_ramaddr", ramaddr, a);
        check("beat_dload_other", dload[o], 32'h0);
        if (wb || supply) begin
          check("beat_ramctl", {ramREN, ramWEN}, 2'b01);
          check("beat_ramstore", ramstore, d[k]);
        end else begin
          check("beat_ramctl", {ramREN, ramWEN}, 2'b10);
        end
        if (!wb) begin
          check("beat_dload", dload[r], supply ? d[k] : gold_rd(a));
          check("beat_ccwait", ccwait, (o == 1) ? 2'b10 : 2'b01);
          check("beat_ccinv", ccinv[o], rdx);
          check("beat_snpaddr", ccsnoopaddr[o], a);
        end else begin
          check("beat_ccwait", ccwait, 2'b00);
        end
        if (acc && ramWEN) ram[ramaddr] = ramstore;
        tick();
      end
      if (wb || supply) golden[a] = d[k];
    end

    cctrans[r] = 1'b0; dREN[r] = 1'b0; dWEN[r] = 1'b0; ccwrite[r] = 1'b0;
    if (supply) begin dWEN[o] = 1'b0; ccwrite[o] = 1'b0; end
    ramstate = R_FREE;
    m_prio   = (r == 0);
  endtask

  // Both cores raise cctrans in the same cycle; the favoured core is served first.
  task automatic pair(input logic [31:0] b0, input logic [31:0] b1);
    int          w;
    logic [31:0] nd [BW];
    for (int k = 0; k < BW; k++) nd[k] = '0;
    cctrans = 2'b11; dREN = 2'b11; ccwrite = 2'b00;
    daddr[0] = b0; daddr[1] = b1;
    w = int'(m_prio);
    serve(w, 1'b0, 1'b0, 1'b0, (w == 1) ? b1 : b0, -1, -1, nd);
    serve(1 - w, 1'b0, 1'b0, 1'b0, (w == 1) ? b0 : b1, -1, -1, nd);
  endtask

  initial begin
    logic [31:0] d [BW];
    int          r;
    bit          wb, rdx, sup;
    logic [31:0] base;

    clear_inputs();
    nRST   = 1'b0;
    m_prio = 1'b0;
    #1;
    check("reset_dwait", dwait, 2'b11);
    check("reset_ccwait", ccwait, 2'b00);
    check("reset_ccinv", ccinv, 2'b00);
    check("reset_snpaddr0", ccsnoopaddr[0], 32'h0);
    check("reset_dload0", dload[0], 32'h0);
    check("reset_ramctl", {ramREN, ramWEN}, 2'b00);
    check("reset_ramaddr", ramaddr, 32'h0);
    check("reset_ramstore", ramstore, 32'h0);
    tick();
    tick();
    nRST = 1'b1;

    // Round-robin: core0 first after reset, then core1, then core0 again.
    pair(32'h500, 32'h600);
    pair(32'h508, 32'h608);

    // Plain load with ACCESS every second cycle.
    ram[32'h40] = 32'hA0; ram[32'h44] = 32'hA4;
    golden[32'h40] = 32'hA0; golden[32'h44] = 32'hA4;
    for (int k = 0; k < BW; k++) d[k] = '0;
    serve(0, 1'b0, 1'b0, 1'b0, 32'h40, 1, -1, d);

    // BusRdX by core1, core0 supplies its Modified block; then RAM must hold it.
    d[0] = 32'hDEAD; d[1] = 32'hBEEF;
    serve(1, 1'b0, 1'b1, 1'b1, 32'h100, -1, -1, d);
    serve(0, 1'b0, 1'b0, 1'b0, 32'h100, 0, -1, d);

    // Eviction, then reload it with a five-cycle stall in every beat.
    d[0] = 32'h1234_5678; d[1] = 32'h9ABC_DEF0;
    serve(0, 1'b1, 1'b0, 1'b0, 32'h200, 2, -1, d);
    serve(1, 1'b0, 1'b0, 1'b0, 32'h200, 5, -1, d);

    // Random traffic over a small set of blocks so loads observe earlier writes.
    for (int t = 0; t < 40; t++) begin
      r    = int'($urandom_range(0, 1));
      wb   = ($urandom_range(0, 3) == 0);
      rdx  = 1'($urandom_range(0, 1));
      sup  = !wb && ($urandom_range(0, 1) == 1);
      base = 32'h300 + 32'($urandom_range(0, 7)) * 32'd8;
      for (int k = 0; k < BW; k++) d[k] = $urandom;
      serve(r, wb, rdx, sup, base, -1, -1, d);
    end

    // Reset during the second C2C beat, then fresh arbitration from the reset priority.
    d[0] = 32'hC0DE_0001; d[1] = 32'hC0DE_0002;
    serve(0, 1'b0, 1'b1, 1'b1, 32'h700, 1, 1, d);
    pair(32'h780, 32'h700);

    @(negedge CLK);
    check("end_idle_ram", {ramREN, ramWEN}, 2'b00);
    check("end_idle_dwait", dwait, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
